// File: rtl/strng_multi_core_pkg.sv
// Shared types for the STR TRNG core: FSM states, debias modes and ring seeding helpers.
package strng_multi_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_RUN    = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    typedef enum logic {
        MODE_RAW = 1'b0,
        MODE_VN  = 1'b1
    } mode_t;

    localparam logic [15:0] JITTER_TAPS = 16'hB400;

    function automatic logic [15:0] jitter_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? JITTER_TAPS : 16'h0000);
    endfunction

    // Every ring gets a distinct non-zero seed so channels never track each other.
    function automatic logic [15:0] ring_seed(input int ch, input int side);
        return 16'(32'hACE1 + ch * 32'h03B7 + side * 32'h1F0B) | 16'h0001;
    endfunction

endpackage

// File: rtl/strng_multi_core_if.sv
// Control and random-word handshake bundle between the TRNG core and its consumer.
interface strng_multi_core_if #(
    parameter int OUT_W = 32
);
    logic             en;
    logic             mode;
    logic             test_en;
    logic             test_bit;
    logic [OUT_W-1:0] rnd_data;
    logic             rnd_valid;
    logic             rnd_ready;
    logic             health_err;

    modport master (
        output en, mode, test_en, test_bit, rnd_ready,
        input  rnd_data, rnd_valid, health_err
    );

    modport slave (
        input  en, mode, test_en, test_bit, rnd_ready,
        output rnd_data, rnd_valid, health_err
    );
endinterface

// File: rtl/strng_multi_core_sampler.sv
// One ring pair with its 4-stage sampler and a 2-flop clk synchronizer per sampled bit.
module strng_multi_core_sampler #(
    parameter int             LEN    = 8,
    parameter logic [LEN-1:0] INIT   = 8'b01010000,
    parameter logic [15:0]    SEED_A = 16'hACE1,
    parameter logic [15:0]    SEED_B = 16'h1D2B
) (
    input  logic           clk,
    input  logic           rstn,
    output logic [LEN-1:0] sync_bits
);

    logic [LEN-1:0] ring_a;
    logic [LEN-1:0] ring_b;
    logic           strb;
    logic           strb_q;
    logic [LEN-1:0] stage0;
    logic [LEN-1:0] stage0_q;
    logic [LEN-1:0] stage1;
    logic [LEN-1:0] stage2;
    logic [LEN-1:0] rise0;
    logic [LEN-1:0] sync1;

    strng_multi_core_str #(.LEN(LEN), .INIT(INIT), .SEED(SEED_A)) u_ring_a (
        .clk  (clk),
        .rstn (rstn),
        .ring (ring_a)
    );

    strng_multi_core_str #(.LEN(LEN), .INIT(INIT), .SEED(SEED_B)) u_ring_b (
        .clk  (clk),
        .rstn (rstn),
        .ring (ring_b)
    );

    // Ring parity flips on every token move, which makes it the strobe.
    assign strb  = ^ring_b;
    assign rise0 = stage0 & ~stage0_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            strb_q    <= 1'b0;
            stage0    <= '0;
            stage0_q  <= '0;
            stage1    <= '0;
            stage2    <= '0;
            sync1     <= '0;
            sync_bits <= '0;
        end else begin
            strb_q <= strb;
            if (strb && !strb_q) begin
                stage0 <= ring_a ^ stage1;
                stage1 <= stage0;
            end
            stage0_q  <= stage0;
            stage2    <= (stage2 & ~rise0) | (stage1 & rise0);
            sync1     <= stage2;
            sync_bits <= sync1;
        end
    end

endmodule

// File: rtl/strng_multi_core_str.sv
// Clocked stand-in for a self-timed ring: tokens advance into bubbles on stages whose
// pseudo-random jitter enable fires, so the ring evolves irregularly but deterministically.
module strng_multi_core_str
    import strng_multi_core_pkg::*;
#(
    parameter int          LEN  = 8,
    parameter logic [LEN-1:0] INIT = 8'b01010000,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic           clk,
    input  logic           rstn,
    output logic [LEN-1:0] ring
);

    logic [15:0]    jitter;
    logic [LEN-1:0] fire;
    logic [LEN-1:0] ring_nx;

    for (genvar i = 0; i < LEN; i++) begin : g_stage
        localparam int P = (i + LEN - 1) % LEN;
        localparam int N = (i + 1) % LEN;
        // Muller stage: copies its predecessor only while predecessor and successor differ.
        assign fire[i]    = jitter[i % 16] ^ jitter[15 - (i % 16)];
        assign ring_nx[i] = (fire[i] && (ring[P] != ring[N])) ? ring[P] : ring[i];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            jitter <= SEED;
            ring   <= INIT;
        end else begin
            jitter <= jitter_step(jitter);
            ring   <= ring_nx;
        end
    end

endmodule

// File: rtl/strng_multi_core.sv
// Multi-channel STR TRNG: folds sampled ring bits into one raw bit per clock, optionally
// debiases it, packs words for a valid/ready consumer and runs a repetition-count test.
module strng_multi_core
    import strng_multi_core_pkg::*;
#(
    parameter int                 NUM_CH     = 2,
    parameter int                 STR_LEN    = 8,
    parameter logic [STR_LEN-1:0] STR_INIT   = 8'b01010000,
    parameter int                 OUT_W      = 32,
    parameter int                 WARMUP_CYC = 64,
    parameter int                 RCT_LIM    = 32
) (
    input logic               clk,
    input logic               rstn,
    strng_multi_core_if.slave bus
);

    localparam int WW = $clog2(WARMUP_CYC + 1);
    localparam int BW = $clog2(OUT_W);
    localparam int RW = $clog2(RCT_LIM + 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYC - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(OUT_W - 1);
    localparam logic [RW-1:0] RUN_LIM   = RW'(RCT_LIM);

    state_t               state;
    state_t               state_nx;
    mode_t                mode_q;
    logic [WW-1:0]        warm_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [RW-1:0]        run_cnt;
    logic [RW-1:0]        run_nx;
    logic                 last_r;
    logic                 phase;
    logic                 b0;
    logic [OUT_W-1:0]     shreg;
    logic [OUT_W-1:0]     shreg_nx;
    logic [OUT_W-1:0]     rnd_data_q;
    logic                 rnd_valid_q;
    logic                 health_err_q;
    logic [NUM_CH*STR_LEN-1:0] sync_all;
    logic                 raw_bit;
    logic                 hc_active;
    logic                 trip;
    logic                 accept;
    logic                 acc_bit;
    logic                 word_done;
    logic                 transfer;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        strng_multi_core_sampler #(
            .LEN    (STR_LEN),
            .INIT   (STR_INIT),
            .SEED_A (ring_seed(c, 0)),
            .SEED_B (ring_seed(c, 1))
        ) u_sampler (
            .clk       (clk),
            .rstn      (rstn),
            .sync_bits (sync_all[c*STR_LEN +: STR_LEN])
        );
    end

    assign raw_bit        = bus.test_en ? bus.test_bit : ^sync_all;
    assign transfer       = rnd_valid_q & bus.rnd_ready;
    assign bus.rnd_data   = rnd_data_q;
    assign bus.rnd_valid  = rnd_valid_q;
    assign bus.health_err = health_err_q;

    always_comb begin
        hc_active = (state == ST_RUN) || (state == ST_HOLD);
        run_nx    = (run_cnt == '0 || raw_bit != last_r) ? RW'(1) : run_cnt + 1'b1;
        trip      = bus.en && hc_active && (run_nx >= RUN_LIM);
        accept    = 1'b0;
        acc_bit   = raw_bit;
        if (state == ST_RUN && bus.en) begin
            if (mode_q == MODE_RAW) begin
                accept = 1'b1;
            end else if (phase) begin
                accept  = (raw_bit != b0);
                acc_bit = b0;
            end
        end
        word_done = accept && (bit_cnt == BIT_LAST) && !trip;
        shreg_nx  = {shreg[OUT_W-2:0], acc_bit};
    end

    // Dropping en wins over every other transition.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (bus.en) state_nx = ST_WARMUP;
            ST_WARMUP: if (warm_cnt == WARM_LAST) state_nx = ST_RUN;
            ST_RUN: begin
                if (trip)                              state_nx = ST_ERROR;
                else if (word_done && !bus.rnd_ready)  state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (trip)          state_nx = ST_ERROR;
                else if (transfer) state_nx = ST_RUN;
            end
            ST_ERROR:  state_nx = ST_ERROR;
            default:   state_nx = ST_IDLE;
        endcase
        if (!bus.en) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q   <= MODE_RAW;
            warm_cnt <= '0;
            bit_cnt  <= '0;
            run_cnt  <= '0;
            last_r   <= 1'b0;
            phase    <= 1'b0;
            b0       <= 1'b0;
            shreg    <= '0;
        end else if (state == ST_IDLE) begin
            if (bus.en) begin
                mode_q   <= mode_t'(bus.mode);
                warm_cnt <= '0;
                bit_cnt  <= '0;
                run_cnt  <= '0;
                phase    <= 1'b0;
            end
        end else if (bus.en) begin
            if (state == ST_WARMUP) warm_cnt <= warm_cnt + 1'b1;
            if (state == ST_HOLD)   phase <= 1'b0;
            if (hc_active) begin
                run_cnt <= run_nx;
                last_r  <= raw_bit;
            end
            if (state == ST_RUN && mode_q == MODE_VN) begin
                phase <= ~phase;
                if (!phase) b0 <= raw_bit;
            end
            if (accept) begin
                shreg   <= shreg_nx;
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    // A completing word may land on the same edge as a transfer and simply replaces it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rnd_data_q   <= '0;
            rnd_valid_q  <= 1'b0;
            health_err_q <= 1'b0;
        end else begin
            if (!bus.en || trip) begin
                rnd_valid_q <= 1'b0;
            end else if (word_done) begin
                rnd_valid_q <= 1'b1;
                rnd_data_q  <= shreg_nx;
            end else if (transfer) begin
                rnd_valid_q <= 1'b0;
            end
            if (!bus.en)   health_err_q <= 1'b0;
            else if (trip) health_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_strng_multi_core.sv
// Directed bench for strng_multi_core: injected-bit word assembly, debiasing, backpressure,
// health test and reset, plus a free-running ring-mode instance checked for clean words.
module tb_strng_multi_core;
    import strng_multi_core_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   check_count = 0;
    int   error_count = 0;

    strng_multi_core_if #(.OUT_W(8)) bus();
    strng_multi_core_if #(.OUT_W(8)) ring_bus();

    strng_multi_core #(
        .NUM_CH(2), .STR_LEN(8), .STR_INIT(8'b01010000),
        .OUT_W(8), .WARMUP_CYC(4), .RCT_LIM(4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    strng_multi_core #(
        .NUM_CH(2), .STR_LEN(8), .STR_INIT(8'b01010000),
        .OUT_W(8), .WARMUP_CYC(4), .RCT_LIM(32)
    ) dut_ring (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ring_bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic bit_in, input logic ready);
        bus.test_bit  = bit_in;
        bus.rnd_ready = ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic feedWord(input logic [7:0] w, input logic ready_first, input logic ready_rest,
                            input string tag);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(w[i], (i == 7) ? ready_first : ready_rest);
            if (i == 1) checkOutput({tag, "_valid_pre"}, 32'(bus.rnd_valid), 32'd0);
        end
        checkOutput({tag, "_valid"}, 32'(bus.rnd_valid), 32'd1);
        checkOutput({tag, "_data"}, 32'(bus.rnd_data), 32'(w));
    endtask

    task automatic warmupToRun(input string tag);
        applyStimulus(1'b0, 1'b0);
        checkOutput({tag, "_warmup"}, 32'(dut.state), 32'(ST_WARMUP));
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput({tag, "_warm_state"}, 32'(dut.state), (k == 4) ? 32'(ST_RUN) : 32'(ST_WARMUP));
            checkOutput({tag, "_warm_bitcnt"}, 32'(dut.bit_cnt), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] vn_pat;
        int words;
        int xbad;
        int trips;

        bus.en = 1'b0; bus.mode = 1'b0; bus.test_en = 1'b0; bus.test_bit = 1'b0; bus.rnd_ready = 1'b0;
        ring_bus.en = 1'b0; ring_bus.mode = 1'b0; ring_bus.test_en = 1'b0;
        ring_bus.test_bit = 1'b0; ring_bus.rnd_ready = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_data", 32'(bus.rnd_data), 32'd0);
        checkOutput("reset_valid", 32'(bus.rnd_valid), 32'd0);
        checkOutput("reset_herr", 32'(bus.health_err), 32'd0);
        checkOutput("reset_state", 32'(dut.state), 32'(ST_IDLE));
        rstn = 1'b1;
        @(negedge clk);

        // Raw mode, then backpressure across a HOLD period.
        bus.en = 1'b1; bus.test_en = 1'b1; bus.mode = MODE_RAW;
        warmupToRun("raw");
        feedWord(8'hB2, 1'b1, 1'b1, "raw");
        checkOutput("raw_state", 32'(dut.state), 32'(ST_RUN));
        feedWord(8'h5C, 1'b1, 1'b0, "bp");
        checkOutput("bp_state", 32'(dut.state), 32'(ST_HOLD));
        for (int k = 0; k < 20; k++) begin
            applyStimulus(~k[0], 1'b0);
            checkOutput("hold_valid", 32'(bus.rnd_valid), 32'd1);
            checkOutput("hold_data", 32'(bus.rnd_data), 32'h5C);
            checkOutput("hold_state", 32'(dut.state), 32'(ST_HOLD));
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("xfer_valid", 32'(bus.rnd_valid), 32'd0);
        checkOutput("xfer_state", 32'(dut.state), 32'(ST_RUN));
        feedWord(8'hC9, 1'b1, 1'b1, "post_bp");

        // en low drops valid but keeps the data word.
        bus.en = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("idle_state", 32'(dut.state), 32'(ST_IDLE));
        checkOutput("idle_valid", 32'(bus.rnd_valid), 32'd0);
        checkOutput("idle_data", 32'(bus.rnd_data), 32'hC9);

        // Health test.
        bus.en = 1'b1;
        warmupToRun("hc");
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("hc_err", 32'(bus.health_err), (k == 4) ? 32'd1 : 32'd0);
        end
        checkOutput("hc_state", 32'(dut.state), 32'(ST_ERROR));
        checkOutput("hc_valid", 32'(bus.rnd_valid), 32'd0);
        repeat (2) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("err_sticky", 32'(bus.health_err), 32'd1);
            checkOutput("err_state", 32'(dut.state), 32'(ST_ERROR));
        end
        bus.en = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("err_clear", 32'(bus.health_err), 32'd0);
        checkOutput("err_idle", 32'(dut.state), 32'(ST_IDLE));

        // von Neumann, with the mode pin changed after it has been latched.
        bus.en = 1'b1; bus.mode = MODE_VN;
        applyStimulus(1'b0, 1'b0);
        checkOutput("vn_warmup", 32'(dut.state), 32'(ST_WARMUP));
        bus.mode = MODE_RAW;
        repeat (4) applyStimulus(1'b0, 1'b0);
        vn_pat = 8'b10011100;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(vn_pat[7 - (i % 8)], 1'b0);
            if (i == 26) checkOutput("vn_valid_pre", 32'(bus.rnd_valid), 32'd0);
            if (i == 27) checkOutput("vn_valid", 32'(bus.rnd_valid), 32'd1);
        end
        checkOutput("vn_data", 32'(bus.rnd_data), 32'hAA);
        checkOutput("vn_state", 32'(dut.state), 32'(ST_HOLD));

        // Asynchronous reset in the middle of a word.
        applyStimulus(1'b1, 1'b1);
        checkOutput("pre_rst_state", 32'(dut.state), 32'(ST_RUN));
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        #2 rstn = 1'b0;
        #1;
        checkOutput("rst_data", 32'(bus.rnd_data), 32'd0);
        checkOutput("rst_valid", 32'(bus.rnd_valid), 32'd0);
        checkOutput("rst_herr", 32'(bus.health_err), 32'd0);
        checkOutput("rst_state", 32'(dut.state), 32'(ST_IDLE));
        checkOutput("rst_bitcnt", 32'(dut.bit_cnt), 32'd0);
        @(negedge clk);
        bus.mode = MODE_RAW;
        rstn = 1'b1;
        warmupToRun("post_rst");
        feedWord(8'h6A, 1'b1, 1'b1, "post_rst");

        // Free-running rings; a health trip is cleared by pulsing en low.
        bus.en = 1'b0;
        ring_bus.en = 1'b1; ring_bus.rnd_ready = 1'b1;
        words = 0; xbad = 0; trips = 0;
        for (int cyc = 0; cyc < 40000 && words < 1000; cyc++) begin
            @(negedge clk);
            if (ring_bus.rnd_valid) begin
                words++;
                if ($isunknown(ring_bus.rnd_data)) xbad++;
            end
            if (ring_bus.health_err) begin
                trips++;
                ring_bus.en = 1'b0;
                @(negedge clk);
                ring_bus.en = 1'b1;
            end
        end
        checkOutput("ring_words", 32'(words >= 1000), 32'd1);
        checkOutput("ring_no_x", 32'(xbad), 32'd0);
        $display("[TB] ring mode: %0d words, %0d health trips", words, trips);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
